// File: rtl/reg_file_if.sv
// Bus bundle for reg_file: read, write and clear requests in, read data and status out.
interface reg_file_if #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned NIB_SIZE  = 4
);
    logic                 clr;
    logic                 rd_en;
    logic [NIB_SIZE-1:0]  num1;
    logic [NIB_SIZE-1:0]  num2;
    logic [WORD_SIZE-1:0] out1;
    logic [WORD_SIZE-1:0] out2;
    logic                 out_valid;
    logic                 we;
    logic [NIB_SIZE-1:0]  setnum;
    logic [WORD_SIZE-1:0] setval;
    logic                 ready;

    modport master (
        output clr, rd_en, num1, num2, we, setnum, setval,
        input  out1, out2, out_valid, ready
    );

    modport slave (
        input  clr, rd_en, num1, num2, we, setnum, setval,
        output out1, out2, out_valid, ready
    );
endinterface

// File: rtl/reg_file.sv
// Two-read/one-write register file with registered reads, write-first bypass and a
// cycle-by-cycle clear sweep that is also the only initialisation after reset.
module reg_file #(
    parameter int unsigned WORD_SIZE      = 16,
    parameter int unsigned NIB_SIZE       = 4,
    parameter int unsigned REG_STACK_SIZE = 16,
    parameter bit          ZERO_REG       = 1'b0
) (
    input logic       clk,
    input logic       reset,
    reg_file_if.slave bus
);
    localparam int unsigned        LastIdxInt = REG_STACK_SIZE - 1;
    localparam logic [NIB_SIZE-1:0] LastIdx   = LastIdxInt[NIB_SIZE-1:0];
    // One extra bit so a full 2**NIB_SIZE stack still compares correctly.
    localparam logic [NIB_SIZE:0]   StackLim  = REG_STACK_SIZE[NIB_SIZE:0];

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e               state_q, state_d;
    logic [NIB_SIZE-1:0]  idx_q, idx_d;
    logic                 sweep_wr;
    logic                 wr_acc;
    logic                 rd_acc;
    logic [WORD_SIZE-1:0] rd1, rd2;
    logic [WORD_SIZE-1:0] out1_q, out2_q;
    logic                 out_valid_q;
    logic [WORD_SIZE-1:0] data_q [REG_STACK_SIZE];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StClear;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sweep_wr = 1'b0;
        unique case (state_q)
            StClear: begin
                sweep_wr = 1'b1;
                if (bus.clr) begin
                    idx_d = '0;
                end else if (idx_q == LastIdx) begin
                    state_d = StReady;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StReady: begin
                if (bus.clr) begin
                    state_d = StClear;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        wr_acc = (state_q == StReady) && bus.we && !bus.clr && !reset
                 && ({1'b0, bus.setnum} < StackLim)
                 && !(ZERO_REG && (bus.setnum == '0));
        rd_acc = (state_q == StReady) && bus.rd_en;

        rd1 = data_q[bus.num1];
        if (wr_acc && (bus.num1 == bus.setnum)) rd1 = bus.setval;
        if (({1'b0, bus.num1} >= StackLim) || (ZERO_REG && (bus.num1 == '0))) rd1 = '0;

        rd2 = data_q[bus.num2];
        if (wr_acc && (bus.num2 == bus.setnum)) rd2 = bus.setval;
        if (({1'b0, bus.num2} >= StackLim) || (ZERO_REG && (bus.num2 == '0))) rd2 = '0;
    end

    // Storage is deliberately not reset; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (sweep_wr) begin
                data_q[idx_q] <= '0;
            end else if (wr_acc) begin
                data_q[bus.setnum] <= bus.setval;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out1_q      <= '0;
            out2_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= rd_acc;
            if (rd_acc) begin
                out1_q <= rd1;
                out2_q <= rd2;
            end
        end
    end

    assign bus.out1      = out1_q;
    assign bus.out2      = out2_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ready     = (state_q == StReady);
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, data width in bits.
REQ-002 SHALL have parameter NIB_SIZE, default 4, register-number width in bits.
REQ-003 SHALL have parameter REG_STACK_SIZE, default 16, register count, 2 <= REG_STACK_SIZE <= 2**NIB_SIZE.
REQ-004 SHALL have parameter ZERO_REG, default 0; 1 = register 0 always reads 0 and ignores writes.
REQ-005 SHALL have one clock; reset is synchronous and active-high: ports clk and reset.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 clr  input  1  request clear sweep of all registers.
REQ-009 rd_en  input  1  read request, samples num1/num2.
REQ-010 num1, num2  input  NIB_SIZE each  read register numbers.
REQ-011 out1, out2  output  WORD_SIZE each  registered read data.
REQ-012 out_valid  output  1  out1/out2 valid this cycle.
REQ-013 we  input  1  write request.
REQ-014 setnum  input  NIB_SIZE  write register number.
REQ-015 setval  input  WORD_SIZE  write data.
REQ-016 ready  output  1  high when in state READY.

Function
REQ-017 SHALL implement two states, CLEAR and READY; ready = (state == READY).
REQ-018 In CLEAR, SHALL write 0 to data[idx] each cycle, idx counting 0 .. REG_STACK_SIZE-1, then move to READY on the cycle after idx = REG_STACK_SIZE-1 is cleared; sweep takes exactly REG_STACK_SIZE cycles.
REQ-019 In READY, clr = 1 SHALL move to CLEAR with idx = 0 next cycle; clr in CLEAR SHALL restart idx at 0.
REQ-020 In READY, we = 1 with setnum < REG_STACK_SIZE SHALL update data[setnum] <= setval at the rising edge.
REQ-021 we SHALL be ignored when setnum >= REG_STACK_SIZE, when state is CLEAR, when clr = 1 the same cycle, or when ZERO_REG = 1 and setnum = 0.
REQ-022 In READY, rd_en = 1 SHALL produce out1 = data[num1], out2 = data[num2], out_valid = 1 on the next cycle (latency 1).
REQ-023 Read-during-write: if an accepted write targets num1 or num2 in the same cycle, the corresponding out SHALL return setval (write-first bypass).
REQ-024 Reads of num >= REG_STACK_SIZE, or of register 0 when ZERO_REG = 1, SHALL return 0 with out_valid = 1.
REQ-025 rd_en = 0, or rd_en in CLEAR, SHALL give out_valid = 0 next cycle; out1/out2 SHALL hold their previous values when out_valid = 0.
REQ-026 rd_en = 1 in the same READY cycle as clr = 1 SHALL still complete with pre-clear data.
REQ-027 num1 = num2 SHALL return identical data on both outputs.

Reset
REQ-028 reset = 1 SHALL set state = CLEAR, idx = 0, out1 = 0, out2 = 0, out_valid = 0, ready = 0 at the next rising edge, overriding clr, we and rd_en.
REQ-029 reset asserted mid-sweep or mid-operation SHALL restart the sweep from idx = 0; register contents after the completed sweep SHALL all be 0.
REQ-030 No initial blocks SHALL be relied on for register contents; the post-reset sweep is the only initialisation.

Verification
REQ-031 Reset 1 cycle, defaults -> ready low for exactly 16 cycles after reset deasserts, then high; read of every register returns 0.
REQ-032 Write setnum=5 setval=0x1234, next cycle rd_en num1=5 num2=3 -> one cycle later out1=0x1234, out2=0, out_valid=1.
REQ-033 Same cycle we setnum=7 setval=0xBEEF and rd_en num1=7 num2=7 -> next cycle out1=out2=0xBEEF.
REQ-034 ZERO_REG=1: write setnum=0 setval=0xFFFF, read num1=0 -> out1=0; REG_STACK_SIZE=12: write setnum=13 ignored, read 13 -> 0.
REQ-035 Fill regs 0..15 with 0x100+n, pulse clr -> ready low 16 cycles, we/rd_en ignored meanwhile (out_valid=0), afterwards all regs read 0.
REQ-036 Assert reset at idx=8 of a sweep -> sweep restarts, ready rises exactly 16 cycles after reset deasserts.
